// File: rtl/ifetch_prefetch.sv
// Instruction fetch front end: in-order word fetches with credit-based flow control
// into a small prefetch FIFO that feeds decode as {insn, pc, pc+4}.
module ifetch_prefetch #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    // fetch request channel
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    // fetch response channel (in request order, one per accepted request)
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_rsp_err,
    // control-flow redirect
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    // decode channel
    output logic        o_insn_valid,
    input  logic        i_insn_ready,
    output logic [31:0] o_insn,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_incr,
    output logic        o_insn_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    // Handshakes: a transfer happens on a cycle where valid & ready are both high.
    // A producer holds valid and payload stable until the transfer; only a redirect
    // may withdraw o_req_valid. The response channel has no ready: the credit rule
    // reserves a FIFO slot for every accepted request.

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   data_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic          err_mem_q  [DEPTH];

    logic [31:0]   out_ext;
    logic [31:0]   cnt_ext;
    logic          credit;
    logic          req_accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [31:0]   redirect_pc_aligned;

    always_comb begin
        out_ext             = 32'(outstanding_q);
        cnt_ext             = 32'(count_q);
        credit              = (out_ext < MAX_OUTSTANDING) && ((out_ext + cnt_ext) < DEPTH);
        o_req_valid         = i_rst_n && !i_redirect && credit;
        o_req_addr          = fetch_pc_q;
        req_accept          = o_req_valid && i_req_ready;
        head_valid          = (count_q != '0);
        // A response landing in a redirect cycle is stale by definition.
        push                = i_rsp_valid && !i_redirect && (drop_q == '0);
        pop                 = head_valid && i_insn_ready && !i_redirect;
        redirect_pc_aligned = {i_redirect_pc[31:2], 2'b00};
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + OW'(req_accept) - OW'(i_rsp_valid);
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (i_redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            rsp_pc_d   = redirect_pc_aligned;
            // Everything still in flight after this cycle is stale: the pending drops
            // plus the live requests, less the response retired right now.
            drop_d     = outstanding_q - OW'(i_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (i_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible unless count_q marks it valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= i_rsp_data;
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            err_mem_q[wr_ptr_q]  <= i_rsp_err;
        end
    end

    always_comb begin
        o_insn_valid = head_valid;
        o_insn       = head_valid ? data_mem_q[rd_ptr_q] : 32'd0;
        o_pc         = head_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
        o_insn_err   = head_valid ? err_mem_q[rd_ptr_q] : 1'b0;
        o_pc_incr    = o_pc + 32'd4;
    end

    a_no_orphan_rsp: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_rsp_valid && (outstanding_q == '0)));

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(push && !pop && (count_q == CW'(DEPTH))));

    a_drop_bounded: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        drop_q <= outstanding_q);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: randomized memory/decode/redirect stimulus checked every
// cycle against a transaction-level model (fetch address, in-flight list, expected FIFO).
module tb_ifetch_prefetch;

  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int EW = 65;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_req_valid, i_req_ready;
  logic [31:0] o_req_addr;
  logic        i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_insn_valid, i_insn_ready;
  logic [31:0] o_insn, o_pc, o_pc_incr;
  logic        o_insn_err;

  always #5 clk = ~clk;

  ifetch_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_insn_valid(o_insn_valid), .i_insn_ready(i_insn_ready),
    .o_insn(o_insn), .o_pc(o_pc), .o_pc_incr(o_pc_incr), .o_insn_err(o_insn_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        err;
    int          due;
    int          epoch;
  } req_t;

  // model state: entries packed as {err, pc, data}
  logic [EW-1:0] exp_q[$];
  req_t          inflight[$];
  logic [31:0]   m_fetch_pc;
  int            epoch;
  int            cycle;
  int            tests;
  int            fails;

  // stimulus knobs
  int lat_min, lat_max, rdy_pct, rsp_pct, dec_pct, redir_pct, err_pct;
  logic        force_err8;
  logic        force_redir;
  logic [31:0] force_pc;

  // observation logs for literal checks
  logic        cur_hv;
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_incr_log[$];
  logic        pop_err_log[$];
  logic [31:0] acc_log[$];
  int          pops;
  int          stale_drops;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (force_err8 && (a == 32'h8)) || (int'($urandom_range(99)) < err_pct);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  task automatic set_idle();
    i_req_ready   = 1'b0;
    i_rsp_valid   = 1'b0;
    i_rsp_data    = 32'd0;
    i_rsp_err     = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'd0;
    i_insn_ready  = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    inflight.delete();
    m_fetch_pc = RESET_PC;
    epoch++;
  endtask

  task automatic drive_inputs();
    if (inflight.size() > 0 && inflight[0].due <= cycle && int'($urandom_range(99)) < rsp_pct) begin
      i_rsp_valid = 1'b1;
      i_rsp_data  = data_of(inflight[0].addr);
      i_rsp_err   = inflight[0].err;
    end else begin
      i_rsp_valid = 1'b0;
      i_rsp_data  = $urandom;
      i_rsp_err   = 1'($urandom_range(1));
    end
    i_req_ready  = int'($urandom_range(99)) < rdy_pct;
    i_insn_ready = int'($urandom_range(99)) < dec_pct;
    if (force_redir) begin
      i_redirect    = 1'b1;
      i_redirect_pc = force_pc;
      force_redir   = 1'b0;
    end else begin
      i_redirect    = int'($urandom_range(99)) < redir_pct;
      i_redirect_pc = $urandom;
    end
  endtask

  task automatic check_and_update();
    logic          exp_rv;
    logic          hv;
    logic [EW-1:0] head;
    logic [EW-1:0] pend;
    logic          pend_v;
    req_t          h;
    req_t          r;
    exp_rv = !i_redirect && (inflight.size() < MAXO) && (inflight.size() + exp_q.size() < DEPTH);
    chk("req_valid", 32'(o_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", o_req_addr, m_fetch_pc);
    hv = (exp_q.size() != 0);
    chk("insn_valid", 32'(o_insn_valid), 32'(hv));
    if (hv) begin
      head = exp_q[0];
      chk("insn", o_insn, head[31:0]);
      chk("pc", o_pc, head[63:32]);
      chk("pc_incr", o_pc_incr, head[63:32] + 32'd4);
      chk("insn_err", 32'(o_insn_err), 32'(head[64]));
    end
    cur_hv = o_insn_valid;
    if (hv && i_insn_ready && !i_redirect) begin
      pops++;
      pop_pc_log.push_back(o_pc);
      pop_incr_log.push_back(o_pc_incr);
      pop_err_log.push_back(o_insn_err);
    end
    if (exp_rv && i_req_ready) acc_log.push_back(o_req_addr);

    pend_v = 1'b0;
    pend   = '0;
    if (i_rsp_valid) begin
      h = inflight.pop_front();
      if (!i_redirect && h.epoch == epoch) begin
        pend_v = 1'b1;
        pend   = {h.err, h.addr, data_of(h.addr)};
      end else begin
        stale_drops++;
      end
    end
    if (i_redirect) begin
      exp_q.delete();
      epoch++;
      m_fetch_pc = {i_redirect_pc[31:2], 2'b00};
    end else begin
      if (hv && i_insn_ready) void'(exp_q.pop_front());
      if (pend_v) exp_q.push_back(pend);
    end
    if (exp_rv && i_req_ready) begin
      r.addr  = m_fetch_pc;
      r.err   = err_of(m_fetch_pc);
      r.due   = cycle + int'($urandom_range(lat_max, lat_min));
      r.epoch = epoch;
      inflight.push_back(r);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cycle++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_inputs();
      @(negedge clk);
      check_and_update();
    end
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rdy, input int rsp,
                       input int dec, input int redir, input int err);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; rsp_pct = rsp;
    dec_pct = dec; redir_pct = redir; err_pct = err;
  endtask

  task automatic clear_logs();
    pop_pc_log.delete();
    pop_incr_log.delete();
    pop_err_log.delete();
    acc_log.delete();
    pops = 0;
  endtask

  task automatic wait_head(output logic [31:0] first_pc);
    first_pc = 32'hDEAD_BEEF;
    for (int k = 0; k < 40; k++) begin
      run(1);
      if (cur_hv) begin
        first_pc = o_pc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(o_req_valid), 32'd0);
    chk({tag, "_insn_valid"}, 32'(o_insn_valid), 32'd0);
    chk({tag, "_insn"}, o_insn, 32'd0);
    chk({tag, "_pc"}, o_pc, 32'd0);
    chk({tag, "_insn_err"}, 32'(o_insn_err), 32'd0);
    chk({tag, "_req_addr"}, o_req_addr, RESET_PC);
  endtask

  function automatic logic [31:0] lg_pc(input int i);
    return (pop_pc_log.size() > i) ? pop_pc_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_incr(input int i);
    return (pop_incr_log.size() > i) ? pop_incr_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_err(input int i);
    return (pop_err_log.size() > i) ? 32'(pop_err_log[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_acc(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_pc;
    int s0;
    tests = 0; fails = 0; cycle = 0; epoch = 0; stale_drops = 0;
    force_err8 = 1'b0; force_redir = 1'b0; force_pc = 32'd0;
    knobs(1, 1, 100, 100, 100, 0, 0);
    rst_n = 1'b0;
    set_idle();
    model_reset();
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single-cycle memory, everything ready
    run(20);
    chk("p1_acc0", lg_acc(0), 32'h0);
    chk("p1_acc1", lg_acc(1), 32'h4);
    chk("p1_acc2", lg_acc(2), 32'h8);
    chk("p1_pc0", lg_pc(0), 32'h0);
    chk("p1_pc1", lg_pc(1), 32'h4);
    chk("p1_pc2", lg_pc(2), 32'h8);
    chk("p1_incr0", lg_incr(0), 32'h4);
    chk("p1_incr2", lg_incr(2), 32'hC);
    chk("p1_throughput", 32'(pops >= 16), 32'd1);

    // 2: decode stalls for 10 cycles
    knobs(1, 1, 100, 100, 0, 0, 0);
    run(10);
    chk("p2_model_full", 32'(exp_q.size()), 32'd4);
    chk("p2_req_valid_low", 32'(o_req_valid), 32'd0);
    knobs(1, 1, 100, 100, 100, 0, 0);
    run(12);

    // 3: two-cycle memory, redirect with two requests in flight
    knobs(2, 2, 100, 100, 100, 0, 0);
    for (int k = 0; k < 50 && inflight.size() != 2; k++) run(1);
    chk("p3_inflight_reached", 32'(inflight.size()), 32'd2);
    s0 = stale_drops;
    force_redir = 1'b1;
    force_pc = 32'h100;
    run(1);
    wait_head(first_pc);
    chk("p3_first_pc", first_pc, 32'h100);
    chk("p3_drops", 32'(stale_drops - s0), 32'd2);

    // 4: redirect coinciding with a response and a pop
    knobs(1, 1, 100, 100, 100, 0, 0);
    run(8);
    s0 = stale_drops;
    force_redir = 1'b1;
    force_pc = 32'h200;
    run(1);
    run(1);
    chk("p4_empty_after", 32'(cur_hv), 32'd0);
    wait_head(first_pc);
    chk("p4_first_pc", first_pc, 32'h200);
    chk("p4_drops", 32'(stale_drops - s0), 32'd1);

    // 5: access fault on address 0x8
    knobs(1, 3, 100, 100, 100, 0, 0);
    force_err8 = 1'b1;
    force_redir = 1'b1;
    force_pc = 32'h0;
    clear_logs();
    run(30);
    chk("p5_pc1", lg_pc(1), 32'h4);
    chk("p5_err1", lg_err(1), 32'd0);
    chk("p5_pc2", lg_pc(2), 32'h8);
    chk("p5_err2", lg_err(2), 32'd1);
    chk("p5_pc3", lg_pc(3), 32'hC);
    chk("p5_err3", lg_err(3), 32'd0);
    force_err8 = 1'b0;

    // 6: wrap at the top of the address space, then async reset mid-burst
    knobs(1, 1, 100, 100, 100, 0, 0);
    force_redir = 1'b1;
    force_pc = 32'hFFFF_FFFE;
    run(1);
    clear_logs();
    run(12);
    chk("p6_acc0", lg_acc(0), 32'hFFFF_FFFC);
    chk("p6_acc1", lg_acc(1), 32'h0);
    chk("p6_pc0", lg_pc(0), 32'hFFFF_FFFC);
    chk("p6_incr0", lg_incr(0), 32'h0);
    chk("p6_pc1", lg_pc(1), 32'h0);
    knobs(1, 3, 70, 80, 70, 0, 10);
    run(15);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    knobs(1, 1, 100, 100, 100, 0, 0);
    clear_logs();
    run(6);
    chk("p6_rst_acc0", lg_acc(0), RESET_PC);
    chk("p6_rst_pc0", lg_pc(0), RESET_PC);

    // 7: fully random traffic
    for (int b = 0; b < 12; b++) begin
      knobs(1, int'($urandom_range(5, 1)), int'($urandom_range(100, 30)),
            int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
            int'($urandom_range(8, 0)), int'($urandom_range(20, 0)));
      run(250);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
